// File: rtl/sdram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : sdram_frame_reader
// Purpose  : Read-side streaming stage between sdram_controller and the TFT
//            pixel timing logic. Walks a frame buffer in SDRAM with 4-word
//            read bursts and lands each burst in a small show-ahead pixel
//            FIFO that the TFT side pops one word per pix_rd strobe.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            enable            - allows new bursts to be issued
//            frame_start       - rewinds address to BASE_ADDR, flushes FIFO
//            rd_addr/rd_enable - burst request to the controller
//            busy/rd_data      - controller status and current burst word
//            rd_ready          - pops one burst word from the controller
//            pix_data/pix_valid- FIFO head word / FIFO not empty
//            pix_rd            - pops the FIFO head
//            underflow         - sticky "pop while empty" flag
// Config   : `define FRAME_READER_UNDERFLOW_EN to build the sticky underflow
//            detector; otherwise underflow is tied low.
// Params   : FRAME_WORDS must be a multiple of 4; FIFO_DEPTH must be a power
//            of two and at least 8.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_frame_reader #(
  parameter int HADDR_WIDTH = 22,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 130560,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   frame_start,
  output logic [HADDR_WIDTH-1:0] rd_addr,
  output logic                   rd_enable,
  input  logic                   busy,
  input  logic [15:0]            rd_data,
  output logic                   rd_ready,
  output logic [15:0]            pix_data,
  output logic                   pix_valid,
  input  logic                   pix_rd,
  output logic                   underflow
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  localparam logic [HADDR_WIDTH-1:0] c_base = HADDR_WIDTH'(BASE_ADDR);
  localparam logic [HADDR_WIDTH-1:0] c_end  = HADDR_WIDTH'(BASE_ADDR + FRAME_WORDS);
  // A new burst is only requested when all 4 words are guaranteed to fit.
  localparam logic [c_cnt_w-1:0]     c_fill_limit = c_cnt_w'(FIFO_DEPTH - 4);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_req     = 3'd1;
  localparam logic [2:0] c_st_wait_hi = 3'd2;
  localparam logic [2:0] c_st_wait_lo = 3'd3;
  localparam logic [2:0] c_st_drain   = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [1:0]             wait_cnt_q, wait_cnt_d;
  logic [1:0]             beat_q, beat_d;
  logic [HADDR_WIDTH-1:0] addr_q, addr_d;
  logic [HADDR_WIDTH-1:0] addr_inc;
  logic                   discard_q, discard_d;
  logic                   rd_enable_q, rd_enable_d;
  logic                   rd_ready_q, rd_ready_d;

  logic [15:0]            mem_q [FIFO_DEPTH];
  logic [15:0]            mem_d [FIFO_DEPTH];
  logic [c_ptr_w-1:0]     wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]     rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]     fifo_count_q, fifo_count_d;

  logic                   can_issue;
  logic                   last_beat;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  assign fifo_empty = (fifo_count_q == '0);
  assign last_beat  = (state_q == c_st_drain) && (beat_q == 2'd3);
  assign can_issue  = enable && !busy && (fifo_count_q <= c_fill_limit) && !frame_start;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= c_st_idle;
      wait_cnt_q <= 2'd0;
      beat_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      beat_q     <= beat_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    beat_d     = beat_q;
    case (state_q)
      c_st_idle: begin
        if (can_issue) begin
          state_d = c_st_req;
        end
      end
      c_st_req: begin
        state_d    = c_st_wait_hi;
        wait_cnt_d = 2'd0;
      end
      c_st_wait_hi: begin
        // A request the controller never acknowledged is simply reissued.
        if (busy) begin
          state_d = c_st_wait_lo;
        end else if (wait_cnt_q == 2'd3) begin
          state_d = c_st_req;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      c_st_wait_lo: begin
        if (!busy) begin
          state_d = c_st_drain;
          beat_d  = 2'd0;
        end
      end
      c_st_drain: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = c_st_idle;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, registered off the next state so they line up with it
  // --------------------------------------------------------------------------
  always_comb begin
    rd_enable_d = (state_d == c_st_req);
    rd_ready_d  = (state_d == c_st_drain);
  end

  // --------------------------------------------------------------------------
  // Address walk and discard tracking
  // --------------------------------------------------------------------------
  assign addr_inc = addr_q + HADDR_WIDTH'(4);

  always_comb begin
    addr_d    = addr_q;
    discard_d = discard_q;
    if (frame_start) begin
      addr_d = c_base;
    end else if (last_beat && !discard_q) begin
      addr_d = (addr_inc == c_end) ? c_base : addr_inc;
    end
    // A burst already requested when frame_start arrives belongs to the old
    // frame: it still drains from the controller but is not stored.
    if (last_beat) begin
      discard_d = 1'b0;
    end else if (frame_start && (state_q != c_st_idle)) begin
      discard_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Pixel FIFO (show-ahead)
  // --------------------------------------------------------------------------
  assign push = (state_q == c_st_drain) && !discard_q && !frame_start;
  assign pop  = pix_rd && !fifo_empty && !frame_start;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (frame_start) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = rd_data;
        wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count_d = fifo_count_q + c_cnt_w'(1);
        2'b01:   fifo_count_d = fifo_count_q - c_cnt_w'(1);
        default: fifo_count_d = fifo_count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= c_base;
      discard_q    <= 1'b0;
      rd_enable_q  <= 1'b0;
      rd_ready_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      addr_q       <= addr_d;
      discard_q    <= discard_d;
      rd_enable_q  <= rd_enable_d;
      rd_ready_q   <= rd_ready_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      mem_q        <= mem_d;
    end
  end

  assign rd_addr   = addr_q;
  assign rd_enable = rd_enable_q;
  assign rd_ready  = rd_ready_q;
  assign pix_data  = mem_q[rd_ptr_q];
  assign pix_valid = !fifo_empty;

  // --------------------------------------------------------------------------
  // Sticky underflow detector
  // --------------------------------------------------------------------------
`ifdef FRAME_READER_UNDERFLOW_EN
  logic underflow_q, underflow_d;

  // frame_start clears the flag even if an empty pop lands in the same cycle.
  always_comb begin
    underflow_d = underflow_q;
    if (frame_start) begin
      underflow_d = 1'b0;
    end else if (pix_rd && fifo_empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign underflow = underflow_q;
`else
  assign underflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_frame_reader
// Purpose  : Directed self-checking bench for sdram_frame_reader. Instance A
//            uses default parameters, instance B uses BASE_ADDR=0x100 and
//            FRAME_WORDS=8. Each has a controller model whose burst words
//            equal the burst address plus the beat index.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_frame_reader;

  localparam int BUSY_CYC = 6;
`ifdef FRAME_READER_UNDERFLOW_EN
  localparam logic EXP_UF = 1'b1;
`else
  localparam logic EXP_UF = 1'b0;
`endif

  logic clk;
  logic rst_n;

  logic        enable_a, frame_start_a, rd_enable_a, busy_a, rd_ready_a;
  logic        pix_valid_a, pix_rd_a, underflow_a, drop_a;
  logic [21:0] rd_addr_a;
  logic [15:0] rd_data_a, pix_data_a;

  logic        enable_b, frame_start_b, rd_enable_b, busy_b, rd_ready_b;
  logic        pix_valid_b, pix_rd_b, underflow_b;
  logic [21:0] rd_addr_b;
  logic [15:0] rd_data_b, pix_data_b;

  int vec;
  int errs;
  int rdy_cnt_a;
  logic [21:0] addr_log_a[$];

  sdram_frame_reader dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable_a), .frame_start(frame_start_a),
    .rd_addr(rd_addr_a), .rd_enable(rd_enable_a), .busy(busy_a),
    .rd_data(rd_data_a), .rd_ready(rd_ready_a), .pix_data(pix_data_a),
    .pix_valid(pix_valid_a), .pix_rd(pix_rd_a), .underflow(underflow_a)
  );

  sdram_frame_reader #(.BASE_ADDR('h100), .FRAME_WORDS(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable_b), .frame_start(frame_start_b),
    .rd_addr(rd_addr_b), .rd_enable(rd_enable_b), .busy(busy_b),
    .rd_data(rd_data_b), .rd_ready(rd_ready_b), .pix_data(pix_data_b),
    .pix_valid(pix_valid_b), .pix_rd(pix_rd_b), .underflow(underflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller models: busy rises the cycle after an accepted request, stays
  // high BUSY_CYC cycles, then word k of the burst reads as address + k.
  logic [3:0]  mcnt_a, mcnt_b;
  logic [15:0] mbase_a, mbase_b;
  logic [1:0]  midx_a, midx_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_a <= 1'b0; mcnt_a <= 4'd0; mbase_a <= 16'd0; midx_a <= 2'd0;
    end else if (busy_a) begin
      if (mcnt_a == 4'd1) busy_a <= 1'b0;
      mcnt_a <= mcnt_a - 4'd1;
    end else if (rd_enable_a && !drop_a) begin
      busy_a <= 1'b1; mcnt_a <= 4'(BUSY_CYC);
      mbase_a <= rd_addr_a[15:0]; midx_a <= 2'd0;
    end else if (rd_ready_a) begin
      midx_a <= midx_a + 2'd1;
    end
  end
  assign rd_data_a = mbase_a + 16'(midx_a);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_b <= 1'b0; mcnt_b <= 4'd0; mbase_b <= 16'd0; midx_b <= 2'd0;
    end else if (busy_b) begin
      if (mcnt_b == 4'd1) busy_b <= 1'b0;
      mcnt_b <= mcnt_b - 4'd1;
    end else if (rd_enable_b) begin
      busy_b <= 1'b1; mcnt_b <= 4'(BUSY_CYC);
      mbase_b <= rd_addr_b[15:0]; midx_b <= 2'd0;
    end else if (rd_ready_b) begin
      midx_b <= midx_b + 2'd1;
    end
  end
  assign rd_data_b = mbase_b + 16'(midx_b);

  always @(negedge clk) begin
    if (rd_enable_a) addr_log_a.push_back(rd_addr_a);
    if (rd_ready_a) rdy_cnt_a = rdy_cnt_a + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    @(negedge clk);
    vec++;
    if (rd_addr_a !== 22'd0 || rd_enable_a !== 1'b0 || rd_ready_a !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctl_a: addr=%0h en=%0b rdy=%0b want 0/0/0", rd_addr_a, rd_enable_a, rd_ready_a);
    end
    vec++;
    if (pix_data_a !== 16'd0 || pix_valid_a !== 1'b0 || underflow_a !== 1'b0) begin
      errs++;
      $display("FAIL reset_pix_a: data=%0h valid=%0b uf=%0b want 0/0/0", pix_data_a, pix_valid_a, underflow_a);
    end
    vec++;
    if (rd_addr_b !== 22'h100 || rd_enable_b !== 1'b0 || pix_valid_b !== 1'b0) begin
      errs++;
      $display("FAIL reset_b: addr=%0h en=%0b valid=%0b want 100/0/0", rd_addr_b, rd_enable_b, pix_valid_b);
    end
  endtask

  task automatic test_fill();
    enable_a = 1'b1;
    for (int c = 0; c < 250; c++) begin
      @(negedge clk);
      if (rd_enable_a) begin
        vec++;
        if (rdy_cnt_a > 12) begin
          errs++;
          $display("FAIL fill_reserve: request issued with %0d words stored, want <= 12", rdy_cnt_a);
        end
      end
    end
    vec++;
    if (addr_log_a.size() != 4) begin
      errs++;
      $display("FAIL fill_nreq: %0d requests, want 4", addr_log_a.size());
    end
    for (int i = 0; i < 4 && i < addr_log_a.size(); i++) begin
      vec++;
      if (addr_log_a[i] !== 22'(4 * i)) begin
        errs++;
        $display("FAIL fill_addr[%0d]: got %0h want %0h", i, addr_log_a[i], 4 * i);
      end
    end
    vec++;
    if (rdy_cnt_a != 16 || pix_valid_a !== 1'b1 || pix_data_a !== 16'd0) begin
      errs++;
      $display("FAIL fill_full: words=%0d valid=%0b head=%0h want 16/1/0", rdy_cnt_a, pix_valid_a, pix_data_a);
    end
  endtask

  task automatic test_stream();
    logic [15:0] exp;
    int guard;
    exp = 16'd0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      vec++;
      if (pix_valid_a !== 1'b1 || pix_data_a !== exp) begin
        errs++;
        $display("FAIL stream[%0d]: valid=%0b data=%0h want 1/%0h", i, pix_valid_a, pix_data_a, exp);
      end
      pix_rd_a = 1'b1;
      @(negedge clk);
      pix_rd_a = 1'b0;
      exp = exp + 16'd1;
      repeat (2) @(negedge clk);
    end
    vec++;
    if (underflow_a !== 1'b0) begin
      errs++;
      $display("FAIL stream_uf: underflow=%0b want 0", underflow_a);
    end
    enable_a = 1'b0;
    repeat (30) @(negedge clk);
    guard = 0;
    while (pix_valid_a && guard < 40) begin
      vec++;
      if (pix_data_a !== exp) begin
        errs++;
        $display("FAIL drain: data=%0h want %0h", pix_data_a, exp);
      end
      pix_rd_a = 1'b1;
      @(negedge clk);
      pix_rd_a = 1'b0;
      exp = exp + 16'd1;
      guard++;
    end
    vec++;
    if (pix_valid_a !== 1'b0 || int'(exp) != rdy_cnt_a) begin
      errs++;
      $display("FAIL drain_total: valid=%0b popped=%0d want 0/%0d", pix_valid_a, exp, rdy_cnt_a);
    end
  endtask

  task automatic test_underflow();
    @(negedge clk);
    pix_rd_a = 1'b1;
    @(negedge clk);
    pix_rd_a = 1'b0;
    vec++;
    if (underflow_a !== EXP_UF || pix_valid_a !== 1'b0) begin
      errs++;
      $display("FAIL uf_set: uf=%0b valid=%0b want %0b/0", underflow_a, pix_valid_a, EXP_UF);
    end
    repeat (5) @(negedge clk);
    vec++;
    if (underflow_a !== EXP_UF) begin
      errs++;
      $display("FAIL uf_sticky: uf=%0b want %0b", underflow_a, EXP_UF);
    end
    frame_start_a = 1'b1;
    @(negedge clk);
    frame_start_a = 1'b0;
    vec++;
    if (underflow_a !== 1'b0) begin
      errs++;
      $display("FAIL uf_clear: uf=%0b want 0", underflow_a);
    end
  endtask

  task automatic test_frame_start();
    int r0, n;
    logic seen;
    r0 = rdy_cnt_a;
    enable_a = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin @(negedge clk); n++; seen = rd_enable_a; end
    enable_a = 1'b0;
    vec++;
    if (!seen || rd_addr_a !== 22'd0) begin
      errs++;
      $display("FAIL fs_req_addr: seen=%0b addr=%0h want 1/0", seen, rd_addr_a);
    end
    seen = 1'b0; n = 0;
    while (!seen && n < 30) begin @(negedge clk); n++; seen = rd_ready_a; end
    vec++;
    if (!seen) begin
      errs++;
      $display("FAIL fs_drain_timeout: rd_ready=0 want 1 within 30 cycles");
    end
    @(negedge clk);           // beat 1
    frame_start_a = 1'b1;
    @(negedge clk);
    frame_start_a = 1'b0;
    repeat (10) @(negedge clk);
    vec++;
    if (rdy_cnt_a - r0 != 4 || pix_valid_a !== 1'b0) begin
      errs++;
      $display("FAIL fs_discard: rd_ready pulses=%0d valid=%0b want 4/0", rdy_cnt_a - r0, pix_valid_a);
    end
    enable_a = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin @(negedge clk); n++; seen = rd_enable_a; end
    vec++;
    if (!seen || rd_addr_a !== 22'd0) begin
      errs++;
      $display("FAIL fs_rewind: seen=%0b addr=%0h want 1/0", seen, rd_addr_a);
    end
  endtask

  task automatic test_push_pop_same();
    int beats, guard, npop;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (pix_valid_a !== 1'b1 || pix_data_a !== 16'(i)) begin
        errs++;
        $display("FAIL pp_pre[%0d]: valid=%0b data=%0h want 1/%0h", i, pix_valid_a, pix_data_a, i);
      end
      pix_rd_a = 1'b1;
      @(negedge clk);
    end
    pix_rd_a = 1'b0;
    beats = 0; guard = 0;
    while (beats < 4 && guard < 60) begin
      @(negedge clk); guard++;
      if (rd_ready_a) beats++;
    end
    vec++;
    if (beats < 4) begin
      errs++;
      $display("FAIL pp_timeout: beats=%0d want 4", beats);
    end
    // Beat 3: count is 15, push and pop land on the same edge.
    vec++;
    if (pix_data_a !== 16'd4) begin
      errs++;
      $display("FAIL pp_head: data=%0h want 4", pix_data_a);
    end
    pix_rd_a = 1'b1;
    @(negedge clk);
    pix_rd_a = 1'b0;
    enable_a = 1'b0;
    repeat (10) @(negedge clk);
    npop = 0;
    while (pix_valid_a && npop < 30) begin
      vec++;
      if (pix_data_a !== 16'(5 + npop)) begin
        errs++;
        $display("FAIL pp_data[%0d]: data=%0h want %0h", npop, pix_data_a, 5 + npop);
      end
      pix_rd_a = 1'b1;
      @(negedge clk);
      npop++;
      if (!pix_valid_a) pix_rd_a = 1'b0;
    end
    pix_rd_a = 1'b0;
    vec++;
    if (npop != 15) begin
      errs++;
      $display("FAIL pp_count: words left=%0d want 15", npop);
    end
  endtask

  task automatic test_retry();
    int n;
    logic seen;
    drop_a = 1'b1;
    enable_a = 1'b1;
    seen = 1'b0; n = 0;
    while (!seen && n < 20) begin @(negedge clk); n++; seen = rd_enable_a; end
    vec++;
    if (!seen || rd_addr_a !== 22'd20) begin
      errs++;
      $display("FAIL retry_first: seen=%0b addr=%0h want 1/14", seen, rd_addr_a);
    end
    @(negedge clk);
    drop_a = 1'b0;
    n = 1; seen = 1'b0;
    while (!seen && n < 12) begin @(negedge clk); n++; seen = rd_enable_a; end
    enable_a = 1'b0;
    vec++;
    if (!seen || n != 5 || rd_addr_a !== 22'd20) begin
      errs++;
      $display("FAIL retry_second: seen=%0b gap=%0d addr=%0h want 1/5/14", seen, n, rd_addr_a);
    end
    repeat (30) @(negedge clk);
    vec++;
    if (pix_valid_a !== 1'b1 || pix_data_a !== 16'd20) begin
      errs++;
      $display("FAIL retry_data: valid=%0b data=%0h want 1/14", pix_valid_a, pix_data_a);
    end
  endtask

  task automatic test_wrap();
    logic [21:0] got[3];
    int nreq, n;
    nreq = 0; n = 0;
    enable_b = 1'b1;
    while (nreq < 3 && n < 150) begin
      @(negedge clk); n++;
      if (rd_enable_b) begin got[nreq] = rd_addr_b; nreq++; end
    end
    enable_b = 1'b0;
    vec++;
    if (nreq != 3) begin
      errs++;
      $display("FAIL wrap_nreq: %0d requests want 3", nreq);
    end
    for (int i = 0; i < nreq; i++) begin
      vec++;
      if (got[i] !== ((i == 1) ? 22'h104 : 22'h100)) begin
        errs++;
        $display("FAIL wrap_addr[%0d]: got %0h want %0h", i, got[i], (i == 1) ? 'h104 : 'h100);
      end
    end
    repeat (30) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      vec++;
      if (pix_valid_b !== 1'b1 || pix_data_b !== 16'('h100 + (i % 8))) begin
        errs++;
        $display("FAIL wrap_data[%0d]: valid=%0b data=%0h want 1/%0h", i, pix_valid_b, pix_data_b, 'h100 + (i % 8));
      end
      pix_rd_b = 1'b1;
      @(negedge clk);
      pix_rd_b = 1'b0;
    end
    vec++;
    if (pix_valid_b !== 1'b0) begin
      errs++;
      $display("FAIL wrap_empty: valid=%0b want 0", pix_valid_b);
    end
  endtask

  initial begin
    vec = 0; errs = 0; rdy_cnt_a = 0;
    rst_n = 1'b0;
    enable_a = 1'b0; frame_start_a = 1'b0; pix_rd_a = 1'b0; drop_a = 1'b0;
    enable_b = 1'b0; frame_start_b = 1'b0; pix_rd_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_fill();
    test_stream();
    test_underflow();
    test_frame_start();
    test_push_pop_same();
    test_retry();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
